// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//
// Memory-side responder for the SLC-3 CPU bus. It stands in for the external
// SRAM in on-FPGA and bench builds, using an on-chip word array that answers
// after a fixed, parameterised number of clock cycles.
//
// Each request is latched from the active-low strobes in IDLE. The responder
// then waits LAT cycles, performs the access and pulses Ready for one cycle.
// It stays in HOLD until the CPU releases both strobes, so a strobe that is
// held low never retriggers an access.
//
// Parameters:
//   ADDR_W  number of ADDR bits decoded; array depth is 2**ADDR_W words
//   DATA_W  word width
//   LAT     access latency in clock cycles, legal range 1..15
//
// Ports:
//   Clk            in   system clock, rising edge
//   Reset          in   synchronous, active-high reset
//   ADDR           in   word address from the CPU; only ADDR[ADDR_W-1:0] used
//   OE             in   active-low read strobe
//   WE             in   active-low write strobe (wins over OE when both low)
//   Data_to_SRAM   in   write data from the CPU
//   Data_from_SRAM out  read data to the CPU; holds its value between reads
//   Ready          out  one-cycle pulse when an access completes
//   Busy           out  high in any state other than IDLE
//   RdCount        out  completed reads, saturating (SRAM_ACCESS_COUNT_EN)
//   WrCount        out  completed writes, saturating (SRAM_ACCESS_COUNT_EN)
//   dbg_state_o    out  current FSM state, for observation only
//
// Optional feature macro: SRAM_ACCESS_COUNT_EN
//   When defined, adds the RdCount/WrCount access counters and their ports.
//   When undefined, the counters and ports are absent; nothing else changes.
//
// Handshake: the CPU asserts OE or WE (low); the request is sampled at the
// first rising edge in IDLE. Ready pulses high for exactly one cycle at the
// LAT-th edge after that sampling edge, together with read data for a read.
// The CPU must release both strobes before a new request is accepted; the
// responder returns to IDLE at the first edge where both strobes are high.
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LAT    = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [DATA_W-1:0] Data_to_SRAM,
    output logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Ready,
    output logic              Busy,
`ifdef SRAM_ACCESS_COUNT_EN
    output logic [15:0]       RdCount,
    output logic [15:0]       WrCount,
`endif
    output logic [1:0]        dbg_state_o
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    // The wait counter starts at LAT-1 so that the access lands exactly LAT
    // edges after the sampling edge (one edge per count plus the final one).
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                ready_q, ready_d;

    // Array contents are deliberately left out of reset.
    logic [DATA_W-1:0]   mem [DEPTH];

    // Access-completion strobes from the next-state logic.
    logic                mem_we;
    logic                rd_done;
    logic                wr_done;

    // Upper ADDR bits are ignored, which gives the documented aliasing.
    logic                unused_addr;
    assign unused_addr = ^ADDR[15:ADDR_W];

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        mem_we  = 1'b0;
        rd_done = 1'b0;
        wr_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A cycle with both strobes low is treated as a write only.
                if (!WE) begin
                    addr_d  = ADDR[ADDR_W-1:0];
                    wdata_d = Data_to_SRAM;
                    cnt_d   = LAT_M1;
                    state_d = WR_WAIT;
                end else if (!OE) begin
                    addr_d  = ADDR[ADDR_W-1:0];
                    cnt_d   = LAT_M1;
                    state_d = RD_WAIT;
                end
            end

            RD_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = mem[addr_q];
                    ready_d = 1'b1;
                    rd_done = 1'b1;
                    state_d = HOLD;
                end
            end

            WR_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_we  = 1'b1;
                    ready_d = 1'b1;
                    wr_done = 1'b1;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // Wait for the CPU to drop both strobes so that a held
                // strobe is not mistaken for a new request.
                if (OE && WE) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Word array. A reset arriving on the commit edge aborts the write, so
    // the write enable is qualified with Reset here.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[addr_q] <= wdata_q;
        end
    end

`ifdef SRAM_ACCESS_COUNT_EN
    // -----------------------------------------------------------------------
    // Saturating access counters. They count on the Ready edge; an access
    // aborted by reset never reaches that edge and is not counted.
    // -----------------------------------------------------------------------
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_done && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (wr_done && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign Data_from_SRAM = rdata_q;
    assign Ready          = ready_q;
    assign Busy           = (state_q != IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//
// Directed bench for sram_responder with default parameters (ADDR_W=10,
// DATA_W=16, LAT=2). Inputs change 1 ns after a rising edge and outputs are
// examined at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LAT    = 2;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_WR_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic              Clk;
    logic              Reset;
    logic [15:0]       ADDR;
    logic              OE;
    logic              WE;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              Ready;
    logic              Busy;
    logic [1:0]        dbg_state;
`ifdef SRAM_ACCESS_COUNT_EN
    logic [15:0]       RdCount;
    logic [15:0]       WrCount;
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    sram_responder #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LAT    (LAT)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .OE             (OE),
        .WE             (WE),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .Ready          (Ready),
        .Busy           (Busy),
`ifdef SRAM_ACCESS_COUNT_EN
        .RdCount        (RdCount),
        .WrCount        (WrCount),
`endif
        .dbg_state_o    (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Scoreboard counters
    // -----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present a request and let the sampling edge pass.
    task automatic req(input bit is_wr, input logic [15:0] a, input logic [DATA_W-1:0] d);
        WE           = is_wr ? 1'b0 : 1'b1;
        OE           = is_wr ? 1'b1 : 1'b0;
        ADDR         = a;
        Data_to_SRAM = d;
        step();
    endtask

    // Count edges after the sampling edge until Ready; bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!Ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(Ready), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(LAT));
    endtask

    task automatic release_strobes(input string tag);
        OE = 1'b1;
        WE = 1'b1;
        step();
        check({tag, "_busy_off"}, 32'(Busy), 32'd0);
        check({tag, "_ready_off"}, 32'(Ready), 32'd0);
    endtask

    task automatic write_word(input string tag, input logic [15:0] a, input logic [DATA_W-1:0] d);
        req(1'b1, a, d);
        wait_ready(tag);
        release_strobes(tag);
    endtask

    task automatic read_word(input string tag, input logic [15:0] a, input logic [DATA_W-1:0] exp);
        req(1'b0, a, '0);
        wait_ready(tag);
        check({tag, "_data"}, 32'(Data_from_SRAM), 32'(exp));
        release_strobes(tag);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        int pulses;

        Reset        = 1'b1;
        OE           = 1'b1;
        WE           = 1'b1;
        ADDR         = 16'h0000;
        Data_to_SRAM = 16'h0000;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        check("rst_data", 32'(Data_from_SRAM), 32'h0);
        check("rst_ready", 32'(Ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));

        // Write BEEF @0012, strobe held for one cycle only
        req(1'b1, 16'h0012, 16'hBEEF);
        check("wr1_state", 32'(dbg_state), 32'(S_WR_WAIT));
        check("wr1_busy", 32'(Busy), 32'd1);
        WE           = 1'b1;
        Data_to_SRAM = 16'h0000;
        wait_ready("wr1");
        check("wr1_hold", 32'(dbg_state), 32'(S_HOLD));
        check("wr1_data_untouched", 32'(Data_from_SRAM), 32'h0);
        step();
        check("wr1_idle", 32'(dbg_state), 32'(S_IDLE));
        check("wr1_ready_pulse", 32'(Ready), 32'd0);

        // Read back @0012
        req(1'b0, 16'h0012, '0);
        check("rd1_state", 32'(dbg_state), 32'(S_RD_WAIT));
        wait_ready("rd1");
        check("rd1_data", 32'(Data_from_SRAM), 32'hBEEF);
        release_strobes("rd1");
        check("rd1_data_holds", 32'(Data_from_SRAM), 32'hBEEF);

        // Simultaneous strobes: write wins, read data untouched
        OE           = 1'b0;
        WE           = 1'b0;
        ADDR         = 16'h0003;
        Data_to_SRAM = 16'h1234;
        step();
        check("both_state", 32'(dbg_state), 32'(S_WR_WAIT));
        wait_ready("both");
        check("both_data_unchanged", 32'(Data_from_SRAM), 32'hBEEF);
        release_strobes("both");
        read_word("both_rb", 16'h0003, 16'h1234);

        // Held OE for 10 cycles: exactly one Ready pulse, Busy throughout
        req(1'b0, 16'h0003, '0);
        pulses = 0;
        for (int i = 1; i < 10; i++) begin
            if (Ready) pulses++;
            check("held_busy", 32'(Busy), 32'd1);
            step();
        end
        if (Ready) pulses++;
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_hold", 32'(dbg_state), 32'(S_HOLD));
        check("held_data", 32'(Data_from_SRAM), 32'h1234);
        release_strobes("held");

        // Address latch and alias: 0412 decodes to 0012
        write_word("w0", 16'h0000, 16'h7777);
        req(1'b0, 16'h0412, '0);
        ADDR = 16'h0000;
        wait_ready("alias");
        check("alias_data", 32'(Data_from_SRAM), 32'hBEEF);
        release_strobes("alias");
        read_word("alias400", 16'h0400, 16'h7777);

        // Reset mid-write: pending write must not commit
        write_word("w20", 16'h0020, 16'h5555);
        req(1'b1, 16'h0020, 16'hAAAA);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        WE    = 1'b1;
        check("rstw_ready", 32'(Ready), 32'd0);
        check("rstw_data", 32'(Data_from_SRAM), 32'h0);
        check("rstw_busy", 32'(Busy), 32'd0);
        check("rstw_state", 32'(dbg_state), 32'(S_IDLE));
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstw_no_ready", 32'(Ready), 32'd0);
        end
        read_word("rstw_rb", 16'h0020, 16'h5555);

`ifdef SRAM_ACCESS_COUNT_EN
        // Access counters: reset-aborted read, then 3 writes and 2 reads
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("cnt_rst_rd", 32'(RdCount), 32'd0);
        check("cnt_rst_wr", 32'(WrCount), 32'd0);
        req(1'b0, 16'h0030, '0);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        OE    = 1'b1;
        step();
        write_word("cw0", 16'h0030, 16'h0101);
        write_word("cw1", 16'h0031, 16'h0202);
        write_word("cw2", 16'h0032, 16'h0303);
        read_word("cr0", 16'h0030, 16'h0101);
        read_word("cr1", 16'h0032, 16'h0303);
        check("cnt_wr", 32'(WrCount), 32'd3);
        check("cnt_rd", 32'(RdCount), 32'd2);
        force dut.rd_cnt_q = 16'hFFFF;
        #1;
        release dut.rd_cnt_q;
        read_word("csat", 16'h0031, 16'h0202);
        check("cnt_rd_sat", 32'(RdCount), 32'hFFFF);
        check("cnt_wr_after_sat", 32'(WrCount), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
